// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store sequencer for a word-wide synchronous RAM.
// Sub-word stores read the word, merge the new lane and write it back.
module mem_access_unit #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    MemorySelector,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          busy,
  output logic          done,
  output logic          misalign,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE} state_t;

  state_t        state_reg, state_next;
  logic          we_reg;
  logic [1:0]    sel_reg;
  logic [AW+1:0] addr_reg;
  logic [31:0]   wdata_reg;
  logic          misalign_reg;
  logic [31:0]   rdata_reg;
  logic [31:0]   mem_wdata_reg;

  logic          req_is_word;
  logic          req_misalign;
  logic          lat_is_byte;
  logic          lat_is_half;
  logic [31:0]   load_data;
  logic [31:0]   merged;
  logic          unused_addr_hi;

  // Bits above the RAM word address are deliberately ignored (address wrap).
  assign unused_addr_hi = &{1'b0, addr[31:AW+2]};

  assign req_is_word  = (MemorySelector == 2'b00) || (MemorySelector == 2'b11);
  assign req_misalign = ((MemorySelector == 2'b10) && addr[0]) ||
                        (req_is_word && (addr[1:0] != 2'b00));
  assign lat_is_byte  = (sel_reg == 2'b01);
  assign lat_is_half  = (sel_reg == 2'b10);

  // Per-lane merge: addressed lanes take store data, the rest keep RAM data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic lane_hit;
      assign lane_hit = lat_is_byte ? (addr_reg[1:0] == 2'(gi)) :
                        lat_is_half ? (addr_reg[1] == 1'(gi / 2)) : 1'b1;
      assign merged[8*gi +: 8] = !lane_hit   ? mem_rdata[8*gi +: 8] :
                                 lat_is_byte ? wdata_reg[7:0] :
                                 lat_is_half ? wdata_reg[8*(gi % 2) +: 8] :
                                               wdata_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    load_data = mem_rdata;
    if (lat_is_byte)
      load_data = {24'b0, mem_rdata[8*addr_reg[1:0] +: 8]};
    else if (lat_is_half)
      load_data = {16'b0, mem_rdata[16*addr_reg[1] +: 16]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (req_misalign)
            state_next = DONE;
          else if (we && req_is_word)
            state_next = WR;
          else
            state_next = RD;
        end
      end
      RD: begin
        mem_re     = 1'b1;
        state_next = MERGE;
      end
      MERGE:   state_next = we_reg ? WR : DONE;
      WR: begin
        mem_we     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_reg        <= 1'b0;
      sel_reg       <= 2'b00;
      addr_reg      <= '0;
      wdata_reg     <= 32'h0;
      misalign_reg  <= 1'b0;
      rdata_reg     <= 32'h0;
      mem_wdata_reg <= 32'h0;
    end else begin
      if (state_reg == IDLE && req) begin
        we_reg       <= we;
        sel_reg      <= MemorySelector;
        addr_reg     <= addr[AW+1:0];
        wdata_reg    <= wdata;
        misalign_reg <= req_misalign;
        if (we && req_is_word && !req_misalign)
          mem_wdata_reg <= wdata;
      end
      if (state_reg == MERGE) begin
        if (we_reg)
          mem_wdata_reg <= merged;
        else
          rdata_reg <= load_data;
      end
    end
  end

  assign rdata     = rdata_reg;
  assign misalign  = done & misalign_reg;
  assign mem_addr  = addr_reg[AW+1:2];
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected completions
// and RAM writes; a negedge monitor pops and compares them as they appear.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        busy, done, misalign, mem_re, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] ram [0:1023];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct { int cyc; logic mis; logic [31:0] rd; } done_t;
  typedef struct { int cyc; logic [9:0] a; logic [31:0] d; } wr_t;
  done_t done_q[$];
  wr_t   wr_q[$];

  mem_access_unit #(.AW(10)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .MemorySelector(sel),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .misalign(misalign), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  // Monitor: strobe exclusivity, RAM writes and completions.
  always @(negedge clk) begin
    if (reset_n) begin
      total++;
      if ($countones({mem_re, mem_we, done}) > 1 || (misalign && !done)) begin
        bad++;
        $display("FAIL strobes cyc=%0d re=%b we=%b done=%b mis=%b, required at most one strobe and mis only with done",
                 cyc, mem_re, mem_we, done, misalign);
      end
      if (mem_we) begin
        total++;
        if (wr_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write cyc=%0d addr=%h data=%h, required no write", cyc, mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if (cyc != w.cyc || mem_addr != w.a || mem_wdata != w.d) begin
            bad++;
            $display("FAIL write got cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h",
                     cyc, mem_addr, mem_wdata, w.cyc, w.a, w.d);
          end else
            $display("write cyc=%0d addr=%h data=%h ok", cyc, mem_addr, mem_wdata);
        end
      end
      if (done) begin
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done cyc=%0d mis=%b rdata=%h, required no completion", cyc, misalign, rdata);
        end else begin
          done_t e;
          e = done_q.pop_front();
          if (cyc != e.cyc || misalign != e.mis || rdata != e.rd) begin
            bad++;
            $display("FAIL done got cyc=%0d mis=%b rdata=%h, required cyc=%0d mis=%b rdata=%h",
                     cyc, misalign, rdata, e.cyc, e.mis, e.rd);
          end else
            $display("done cyc=%0d mis=%b rdata=%h ok", cyc, misalign, rdata);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end else
      $display("check %s = %h ok", name, act);
  endtask

  // Called at posedge+2; returns at posedge+2 of cycle 0 of the accepted access.
  task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                       input int lat, input logic mis, input logic [31:0] rd_exp,
                       input int wlat, input logic [9:0] wa, input logic [31:0] wd,
                       input bit hold, input bit track);
    int acc;
    we = w; sel = s; addr = a; wdata = d; req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      @(posedge clk); #2;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL accept_timeout addr=%h busy=%b required busy=0", a, busy);
    end
    acc = cyc + 1;
    if (track) begin
      done_q.push_back('{acc + lat, mis, rd_exp});
      if (wlat >= 0) wr_q.push_back('{acc + wlat, wa, wd});
    end
    @(posedge clk); #2;
    if (!hold) req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #2;
      if (!busy && done_q.size() == 0 && wr_q.size() == 0) break;
    end
    total++;
    if (busy || done_q.size() != 0 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL drain busy=%b pending_done=%0d pending_wr=%0d required all zero",
               busy, done_q.size(), wr_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("reset_flags", {27'b0, busy, done, misalign, mem_re, mem_we}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_mem_addr", {22'b0, mem_addr}, 32'h0);
    #9 reset_n = 1'b1;
    @(posedge clk); #2;

    // word store / load
    issue(1, 2'b00, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0,      0, 10'h004, 32'hDEADBEEF, 0, 1);
    issue(0, 2'b00, 32'h10, 32'h0,        2, 0, 32'hDEADBEEF, -1, 10'h0, 32'h0,     0, 1);
    // byte read-modify-write
    issue(1, 2'b00, 32'h10, 32'h11223344, 1, 0, 32'hDEADBEEF, 0, 10'h004, 32'h11223344, 0, 1);
    issue(1, 2'b01, 32'h12, 32'hFFFFFFAA, 3, 0, 32'hDEADBEEF, 2, 10'h004, 32'h11AA3344, 0, 1);
    // sub-word loads
    issue(1, 2'b00, 32'h14, 32'h8899AABB, 1, 0, 32'hDEADBEEF, 0, 10'h005, 32'h8899AABB, 0, 1);
    issue(0, 2'b01, 32'h17, 32'h0, 2, 0, 32'h00000088, -1, 10'h0, 32'h0, 0, 1);
    issue(0, 2'b10, 32'h16, 32'h0, 2, 0, 32'h00008899, -1, 10'h0, 32'h0, 0, 1);
    issue(0, 2'b01, 32'h14, 32'h0, 2, 0, 32'h000000BB, -1, 10'h0, 32'h0, 0, 1);
    issue(0, 2'b10, 32'h14, 32'h0, 2, 0, 32'h0000AABB, -1, 10'h0, 32'h0, 0, 1);
    // misaligned requests
    issue(1, 2'b00, 32'h20, 32'h55667788, 1, 0, 32'h0000AABB, 0, 10'h008, 32'h55667788, 0, 1);
    issue(1, 2'b10, 32'h21, 32'h00001234, 0, 1, 32'h0000AABB, -1, 10'h0, 32'h0, 0, 1);
    issue(0, 2'b00, 32'h22, 32'h0,        0, 1, 32'h0000AABB, -1, 10'h0, 32'h0, 0, 1);
    issue(0, 2'b00, 32'h20, 32'h0,        2, 0, 32'h55667788, -1, 10'h0, 32'h0, 0, 1);
    // halfword RMW, selector 11 as word
    issue(1, 2'b10, 32'h22, 32'hDEADCAFE, 3, 0, 32'h55667788, 2, 10'h008, 32'hCAFE7788, 0, 1);
    issue(1, 2'b11, 32'h24, 32'h0BADF00D, 1, 0, 32'h55667788, 0, 10'h009, 32'h0BADF00D, 0, 1);
    issue(0, 2'b11, 32'h24, 32'h0,        2, 0, 32'h0BADF00D, -1, 10'h0, 32'h0, 0, 1);
    issue(0, 2'b00, 32'h20, 32'h0,        2, 0, 32'hCAFE7788, -1, 10'h0, 32'h0, 0, 1);
    // address wrap: upper bits ignored
    issue(1, 2'b00, 32'h10000030, 32'hA5A5A5A5, 1, 0, 32'hCAFE7788, 0, 10'h00C, 32'hA5A5A5A5, 0, 1);
    issue(0, 2'b00, 32'h30, 32'h0, 2, 0, 32'hA5A5A5A5, -1, 10'h0, 32'h0, 0, 1);
    // back-to-back with req held high
    issue(1, 2'b01, 32'h31, 32'h0000005A, 3, 0, 32'hA5A5A5A5, 2, 10'h00C, 32'hA5A55AA5, 1, 1);
    issue(0, 2'b00, 32'h30, 32'h0,        2, 0, 32'hA5A55AA5, -1, 10'h0, 32'h0, 1, 1);
    issue(0, 2'b10, 32'h32, 32'h0,        2, 0, 32'h0000A5A5, -1, 10'h0, 32'h0, 1, 1);
    issue(0, 2'b00, 32'h31, 32'h0,        0, 1, 32'h0000A5A5, -1, 10'h0, 32'h0, 1, 1);
    issue(1, 2'b00, 32'h34, 32'h01020304, 1, 0, 32'h0000A5A5, 0, 10'h00D, 32'h01020304, 0, 1);
    wait_idle();

    // req pulse during RD is ignored
    issue(0, 2'b00, 32'h10, 32'h0, 2, 0, 32'h11AA3344, -1, 10'h0, 32'h0, 0, 1);
    we = 1'b1; sel = 2'b00; addr = 32'h10; wdata = 32'hFFFFFFFF; req = 1'b1;
    @(posedge clk); #2;
    req = 1'b0;
    wait_idle();
    chk("pulse_ram4", ram[4], 32'h11AA3344);

    // reset during WR of a byte RMW
    issue(1, 2'b01, 32'h10, 32'h00000077, 3, 0, 32'h0, 2, 10'h004, 32'h11AA3377, 0, 0);
    for (int k = 0; k < 10; k++) begin
      if (mem_we) break;
      @(posedge clk); #2;
    end
    chk("rmw_reached_wr", {31'b0, mem_we}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("midreset_flags", {27'b0, busy, done, misalign, mem_re, mem_we}, 32'h0);
    chk("midreset_rdata", rdata, 32'h0);
    chk("midreset_mem_wdata", mem_wdata, 32'h0);
    chk("midreset_mem_addr", {22'b0, mem_addr}, 32'h0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #2;
    chk("midreset_ram4", ram[4], 32'h11AA3344);
    issue(0, 2'b00, 32'h10, 32'h0, 2, 0, 32'h11AA3344, -1, 10'h0, 32'h0, 0, 1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
